uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 16'hFFFF: max clocks waiting for tx done or for the next locked byte.
REQ-003 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_req_valid  in  N_REQ  per-requester byte valid.
REQ-006 SHALL have port i_req_data  in  8*N_REQ  byte k at bits [8k+7:8k].
REQ-007 SHALL have port i_req_last  in  N_REQ  byte k is last of its message.
REQ-008 SHALL have port o_req_ready  out  N_REQ  combinational accept strobe; transfer = valid & ready.
REQ-009 SHALL have port o_grant  out  N_REQ  registered one-hot owner, all-zero when unowned.
REQ-010 SHALL have port o_tx_data  out  8  byte to UART transmitter.
REQ-011 SHALL have port o_tx_en  out  1  one-cycle start pulse to UART transmitter.
REQ-012 SHALL have port i_tx_busy  in  1  transmitter busy.
REQ-013 SHALL have port i_tx_done  in  1  transmitter one-cycle done pulse.
REQ-014 SHALL have port o_err  out  1  one-cycle timeout pulse.

Function
REQ-015 SHALL implement states ST_IDLE, ST_SEND, ST_WAIT_DONE, ST_HOLD.
REQ-016 ST_IDLE: when i_tx_busy=0 and any valid, SHALL select winner k round-robin starting at pointer ptr, ascending, wrapping N_REQ-1 -> 0, and assert o_req_ready[k] only.
REQ-017 On accept edge SHALL latch o_tx_data <= byte k, o_tx_en <= 1, o_grant <= one-hot k, lock <= ~i_req_last[k], go ST_SEND.
REQ-018 Latency: valid sampled in ST_IDLE with busy low -> o_tx_en high the next cycle (1 clk).
REQ-019 ST_SEND: o_tx_en high exactly this one cycle; next edge o_tx_en <= 0, clear timeout counter, go ST_WAIT_DONE.
REQ-020 ST_WAIT_DONE: on i_tx_done=1, if lock go ST_HOLD (grant kept), else go ST_IDLE, o_grant <= 0, ptr <= (k+1) mod N_REQ.
REQ-021 ST_HOLD: only owner k eligible; when i_req_valid[k] and i_tx_busy=0, assert o_req_ready[k] and accept per REQ-017; other requesters SHALL see ready=0.
REQ-022 o_req_ready SHALL be all-zero in ST_SEND and ST_WAIT_DONE, and at most one bit high in any cycle.
REQ-023 Timeout counter (16 bit) SHALL increment each clock in ST_WAIT_DONE and ST_HOLD; on reaching TIMEOUT_CLKS-1 SHALL pulse o_err one cycle, clear o_grant and lock, advance ptr past k, go ST_IDLE.
REQ-024 i_tx_done arriving in same cycle as timeout terminal count SHALL take priority (no o_err).
REQ-025 i_tx_done outside ST_WAIT_DONE SHALL be ignored.
REQ-026 Requester dropping valid before ready SHALL cause no transfer and no state change.
REQ-027 Minimum gap i_tx_done -> next o_tx_en SHALL be 2 clocks, so the transmitter is idle when sampled.

Reset
REQ-028 While i_rst=1 (asynchronously): state ST_IDLE, o_tx_en=0, o_tx_data=8'h00, o_grant=0, o_err=0, lock=0, ptr=0, counter=0; o_req_ready=0.
REQ-029 Reset mid-transmission SHALL abort without further o_tx_en; first post-reset grant follows ptr=0.

Verification
REQ-030 Single byte: req0 valid, data 8'h41, last=1 -> ready[0] 1 cycle, o_tx_en 1 cycle next clk with o_tx_data 8'h41; done -> grant 0, ptr=1.
REQ-031 Round-robin: all four valid continuously, last=1 -> grants in order 0,1,2,3,0; each o_tx_en >= 2 clks after prior done.
REQ-032 Locked message: req2 sends 8'h10,8'h11,8'h12 (last on third) while req0 valid -> req0 ready stays 0 until 8'h12 done, then req0 (ptr=3 wraps) granted.
REQ-033 Timeout: TIMEOUT_CLKS=16, accept byte, never pulse done -> o_err one cycle 15 clks after entering ST_WAIT_DONE, grant cleared, ST_IDLE.
REQ-034 Hold timeout: req1 sends byte with last=0 then drops valid -> o_err after TIMEOUT_CLKS-1 clks in ST_HOLD, req2 then grantable.
REQ-035 Reset in ST_WAIT_DONE -> all outputs per REQ-028 within the reset cycle; next request to req3 alone still accepted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter. A requester that sends a
// non-last byte keeps ownership until its message ends or the owner times out.
module uart_tx_arbiter #(
  parameter int          N_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CLKS = 16'hFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_en,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_err,
  output logic [1:0]         dbg_state
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [15:0] TERM = TIMEOUT_CLKS - 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

  state_t        state;
  logic          lock;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [15:0]   cnt;

  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [IW-1:0] acc_idx;
  logic          accept;
  logic [IW-1:0] next_ptr;
  logic [15:0]   cnt_inc;
  logic          terminal;

  // Handshake: a byte moves on a clock edge where i_req_valid[k] & o_req_ready[k];
  // ready never depends on anything but the current state, busy and valids.

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && i_req_valid[rr_idx(ptr, i)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(ptr, i);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (!i_rst && !i_tx_busy) begin
      case (state)
        ST_IDLE: if (win_found) o_req_ready[win_idx] = 1'b1;
        ST_HOLD: if (i_req_valid[owner]) o_req_ready[owner] = 1'b1;
        default: ;
      endcase
    end
  end

  assign accept    = |(i_req_valid & o_req_ready);
  assign acc_idx   = (state == ST_HOLD) ? owner : win_idx;
  assign next_ptr  = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign cnt_inc   = cnt + 16'd1;
  assign terminal  = (cnt_inc == TERM);
  assign dbg_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_tx_en   <= 1'b0;
      o_tx_data <= 8'h00;
      o_grant   <= '0;
      o_err     <= 1'b0;
      lock      <= 1'b0;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
    end else begin
      o_err <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            o_tx_data <= i_req_data[8*acc_idx +: 8];
            o_tx_en   <= 1'b1;
            o_grant   <= N_REQ'(1) << acc_idx;
            owner     <= acc_idx;
            lock      <= ~i_req_last[acc_idx];
            state     <= ST_SEND;
          end else if (state == ST_HOLD) begin
            if (terminal) begin
              o_err   <= 1'b1;
              o_grant <= '0;
              lock    <= 1'b0;
              ptr     <= next_ptr;
              cnt     <= '0;
              state   <= ST_IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_SEND: begin
          o_tx_en <= 1'b0;
          cnt     <= '0;
          state   <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // A done pulse on the terminal count wins over the timeout.
          if (i_tx_done) begin
            cnt <= '0;
            if (lock) begin
              state <= ST_HOLD;
            end else begin
              o_grant <= '0;
              ptr     <= next_ptr;
              state   <= ST_IDLE;
            end
          end else if (terminal) begin
            o_err   <= 1'b1;
            o_grant <= '0;
            lock    <= 1'b0;
            ptr     <= next_ptr;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, round-robin order, locked
// messages, both timeouts, done/timeout collision and mid-transfer reset.
module tb_uart_tx_arbiter;

  localparam int          N  = 4;
  localparam logic [15:0] TO = 16'd16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_en;
  logic           tx_busy;
  logic           tx_done;
  logic           err;
  logic [1:0]     state;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CLKS(TO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_grant     (grant),
    .o_tx_data   (tx_data),
    .o_tx_en     (tx_en),
    .i_tx_busy   (tx_busy),
    .i_tx_done   (tx_done),
    .o_err       (err),
    .dbg_state   (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    req_data = {b3, b2, b1, b0};
  endtask

  // Present valids, expect a grant, then follow the byte through SEND into WAIT_DONE.
  task automatic xfer(input string tag, input logic [3:0] valid, input logic [3:0] last,
                      input logic [3:0] exp_rdy, input logic [7:0] exp_data);
    req_valid = valid;
    req_last  = last;
    #1;
    check_val({tag, " pre_en"}, tx_en, 0);
    check_val({tag, " ready"}, req_ready, exp_rdy);
    cyc();
    check_val({tag, " en"}, tx_en, 1);
    check_val({tag, " data"}, tx_data, exp_data);
    check_val({tag, " grant"}, grant, exp_rdy);
    check_val({tag, " st_send"}, state, S_SEND);
    check_val({tag, " rdy_send"}, req_ready, 0);
    cyc();
    check_val({tag, " en_off"}, tx_en, 0);
    check_val({tag, " st_wait"}, state, S_WAIT);
    check_val({tag, " rdy_wait"}, req_ready, 0);
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
  endtask

  logic [3:0] rr_exp [5];
  logic [7:0] rr_data [5];

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0001;
    req_last  = 4'b1111;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    set_bytes(8'hA0, 8'hA1, 8'hA2, 8'hA3);

    // reset state
    repeat (2) cyc();
    check_val("rst ready", req_ready, 0);
    check_val("rst state", state, S_IDLE);
    check_val("rst grant", grant, 0);
    check_val("rst en", tx_en, 0);
    check_val("rst data", tx_data, 8'h00);
    check_val("rst err", err, 0);
    rst = 1'b0;

    // busy transmitter blocks grants
    tx_busy = 1'b1;
    #1;
    check_val("busy ready", req_ready, 0);
    cyc();
    check_val("busy state", state, S_IDLE);
    tx_busy = 1'b0;

    // single byte
    set_bytes(8'h41, 8'hA1, 8'hA2, 8'hA3);
    xfer("single", 4'b0001, 4'b1111, 4'b0001, 8'h41);
    done_pulse();
    check_val("single grant_clr", grant, 0);
    check_val("single idle", state, S_IDLE);
    xfer("ptr1", 4'b0011, 4'b1111, 4'b0010, 8'hA1);
    req_valid = '0;
    done_pulse();

    // round robin from ptr=0 after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_bytes(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    for (int i = 0; i < 5; i++) begin
      xfer($sformatf("rr%0d", i), 4'b1111, 4'b1111, rr_exp[i], rr_data[i]);
      done_pulse();
    end
    req_valid = '0;

    // locked three-byte message from req2 while req0 waits
    set_bytes(8'hA0, 8'hA1, 8'h10, 8'hA3);
    xfer("lock0", 4'b0101, 4'b0000, 4'b0100, 8'h10);
    done_pulse();
    check_val("lock hold", state, S_HOLD);
    check_val("lock grant", grant, 4'b0100);
    req_valid = 4'b0001;
    #1;
    check_val("lock other_rdy", req_ready, 0);
    cyc();
    check_val("lock stay", state, S_HOLD);
    set_bytes(8'hA0, 8'hA1, 8'h11, 8'hA3);
    xfer("lock1", 4'b0101, 4'b0000, 4'b0100, 8'h11);
    done_pulse();
    set_bytes(8'hA0, 8'hA1, 8'h12, 8'hA3);
    xfer("lock2", 4'b0101, 4'b0100, 4'b0100, 8'h12);
    done_pulse();
    check_val("lock end_idle", state, S_IDLE);
    check_val("lock end_grant", grant, 0);
    xfer("wrap", 4'b0101, 4'b1111, 4'b0001, 8'hA0);
    req_valid = '0;
    done_pulse();

    // timeout waiting for done
    set_bytes(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    xfer("tmo", 4'b0010, 4'b1111, 4'b0010, 8'hA1);
    req_valid = '0;
    check_val("tmo err0", err, 0);
    for (int i = 1; i < 15; i++) begin
      cyc();
      check_val($sformatf("tmo quiet%0d", i), err, 0);
    end
    cyc();
    check_val("tmo err", err, 1);
    check_val("tmo grant", grant, 0);
    check_val("tmo idle", state, S_IDLE);
    cyc();
    check_val("tmo err_pulse", err, 0);

    // done on the terminal count beats the timeout
    xfer("prio", 4'b0100, 4'b1111, 4'b0100, 8'hA2);
    req_valid = '0;
    repeat (14) cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    check_val("prio err", err, 0);
    check_val("prio idle", state, S_IDLE);
    check_val("prio grant", grant, 0);
    cyc();
    check_val("prio err_late", err, 0);

    // hold timeout after a non-last byte; stray done in HOLD is ignored
    xfer("hold", 4'b0010, 4'b0000, 4'b0010, 8'hA1);
    req_valid = '0;
    done_pulse();
    check_val("hold state", state, S_HOLD);
    check_val("hold grant", grant, 4'b0010);
    done_pulse();
    check_val("hold stray_done", state, S_HOLD);
    check_val("hold err_early", err, 0);
    repeat (13) cyc();
    check_val("hold err14", err, 0);
    check_val("hold still", state, S_HOLD);
    cyc();
    check_val("hold err", err, 1);
    check_val("hold grant_clr", grant, 0);
    check_val("hold idle", state, S_IDLE);
    xfer("after_hold", 4'b0110, 4'b1111, 4'b0100, 8'hA2);
    req_valid = '0;
    done_pulse();

    // reset while waiting for done
    xfer("rst_mid", 4'b1000, 4'b1111, 4'b1000, 8'hA3);
    req_valid = 4'b1000;
    rst = 1'b1;
    #1;
    check_val("rstmid grant", grant, 0);
    check_val("rstmid en", tx_en, 0);
    check_val("rstmid data", tx_data, 8'h00);
    check_val("rstmid state", state, S_IDLE);
    check_val("rstmid ready", req_ready, 0);
    check_val("rstmid err", err, 0);
    cyc();
    check_val("rstmid en_held", tx_en, 0);
    rst = 1'b0;
    xfer("post_rst", 4'b1000, 4'b1111, 4'b1000, 8'hA3);
    req_valid = '0;
    done_pulse();
    check_val("post_rst idle", state, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
